// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl_if  -- ID-stage hazard/forwarding bus bundle
// Rev    : 1.0
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             hold;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic             load_stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output hold, flush, id_valid, id_rn, id_rm, id_use_rn, id_use_rm,
               id_rd, id_regwrite, id_memread,
        input  ex_fwd_a, ex_fwd_b, load_stall, stall_count
    );

    modport slave (
        input  hold, flush, id_valid, id_rn, id_rm, id_use_rn, id_use_rm,
               id_rd, id_regwrite, id_memread,
        output ex_fwd_a, ex_fwd_b, load_stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl  -- forwarding select / load-use stall controller
// Option : FWD_REGFILE_BYPASS_EN (regfile write-before-read, WB match -> 00)
// Rev    : 1.0
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    fwd_hazard_ctrl_if.slave bus
);

    localparam logic [REG_W-1:0] c_ZERO    = REG_W'(ZERO_REG);
    localparam logic [1:0]       c_SEL_RF  = 2'b00;
    localparam logic [1:0]       c_SEL_EX  = 2'b01;
    localparam logic [1:0]       c_SEL_MEM = 2'b10;
`ifdef FWD_REGFILE_BYPASS_EN
    localparam logic [1:0]       c_SEL_WB  = 2'b00;
`else
    localparam logic [1:0]       c_SEL_WB  = 2'b11;
`endif

    typedef struct packed {
        logic             v;
        logic             wr;
        logic             ld;
        logic [REG_W-1:0] rd;
    } slot_t;

    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             w_rn_qual, w_rm_qual;
    logic [1:0]       w_sel_a, w_sel_b;
    logic             w_load_stall;

    function automatic logic writing(input slot_t s);
        return s.v & s.wr & (s.rd != c_ZERO);
    endfunction

    // Nearest in-flight producer wins.
    function automatic logic [1:0] fwd_sel(input logic qual, input logic [REG_W-1:0] src,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (qual) begin
            if (writing(ex) && ex.rd == src)        sel = c_SEL_EX;
            else if (writing(mem) && mem.rd == src) sel = c_SEL_MEM;
            else if (writing(wb) && wb.rd == src)   sel = c_SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        w_rn_qual = bus.id_use_rn & bus.id_valid & (bus.id_rn != c_ZERO);
        w_rm_qual = bus.id_use_rm & bus.id_valid & (bus.id_rm != c_ZERO);
        w_sel_a   = fwd_sel(w_rn_qual, bus.id_rn, ex_q, mem_q, wb_q);
        w_sel_b   = fwd_sel(w_rm_qual, bus.id_rm, ex_q, mem_q, wb_q);

        // A load in EX cannot forward yet; a flushed consumer needs no stall.
        w_load_stall = bus.id_valid & ex_q.v & ex_q.ld & (ex_q.rd != c_ZERO)
                     & ((w_rn_qual & (bus.id_rn == ex_q.rd)) | (w_rm_qual & (bus.id_rm == ex_q.rd)))
                     & ~bus.flush;
    end

    always_comb begin
        ex_d        = '0;
        fwd_a_d     = c_SEL_RF;
        fwd_b_d     = c_SEL_RF;
        stall_cnt_d = stall_cnt_q;

        if (!(bus.flush || w_load_stall)) begin
            ex_d.v  = bus.id_valid;
            ex_d.wr = bus.id_regwrite;
            ex_d.ld = bus.id_memread;
            ex_d.rd = bus.id_rd;
            fwd_a_d = w_sel_a;
            fwd_b_d = w_sel_b;
        end

        if (w_load_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= c_SEL_RF;
            fwd_b_q     <= c_SEL_RF;
            stall_cnt_q <= '0;
        end else if (!bus.hold) begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ex_fwd_a    = fwd_a_q;
    assign bus.ex_fwd_b    = fwd_b_q;
    assign bus.load_stall  = w_load_stall;
    assign bus.stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fwd_hazard_ctrl  -- scoreboard bench for fwd_hazard_ctrl
// Rev    : 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;

    localparam int         REG_W = 5;
    localparam int         CNT_W = 8;
    localparam logic [4:0] XZR   = 5'd31;
`ifdef FWD_REGFILE_BYPASS_EN
    localparam logic [1:0] WB_CODE = 2'b00;
`else
    localparam logic [1:0] WB_CODE = 2'b11;
`endif

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_ctrl #(.REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    // Reference pipe: index 0 = EX, 1 = MEM, 2 = WB
    logic             m_v  [3];
    logic             m_wr [3];
    logic             m_ld [3];
    logic [4:0]       m_rd [3];
    logic [1:0]       m_fa, m_fb;
    logic [CNT_W-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sel(input logic qual, input logic [4:0] s);
        logic [1:0] r;
        r = 2'b00;
        if (qual) begin
            for (int i = 2; i >= 0; i--) begin
                if (m_v[i] && m_wr[i] && m_rd[i] != XZR && m_rd[i] == s)
                    r = (i == 0) ? 2'b01 : (i == 1) ? 2'b10 : WB_CODE;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0; m_wr[i] = 1'b0; m_ld[i] = 1'b0; m_rd[i] = 5'd0;
        end
        m_fa = 2'b00; m_fb = 2'b00; m_cnt = '0;
    endtask

    // One clock: drive ID, check the stall, predict, clock, compare EX outputs.
    task automatic cyc(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl, input logic hd,
                       output logic stalled);
        exp_t       e;
        logic       qa, qb, exp_stall;
        logic [1:0] sel_a, sel_b;
        bus.id_valid = v;   bus.id_rn = rn;        bus.id_rm = rm;
        bus.id_use_rn = urn; bus.id_use_rm = urm;  bus.id_rd = rd;
        bus.id_regwrite = rw; bus.id_memread = ld; bus.flush = fl; bus.hold = hd;
        #1;
        qa = urn && v && rn != XZR;
        qb = urm && v && rm != XZR;
        exp_stall = v && m_v[0] && m_ld[0] && m_rd[0] != XZR &&
                    ((qa && rn == m_rd[0]) || (qb && rm == m_rd[0])) && !fl;
        check("load_stall", {31'd0, bus.load_stall}, {31'd0, exp_stall});
        stalled = exp_stall;
        if (!hd) begin
            sel_a = m_sel(qa, rn);
            sel_b = m_sel(qb, rm);
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1]; m_wr[i] = m_wr[i-1]; m_ld[i] = m_ld[i-1]; m_rd[i] = m_rd[i-1];
            end
            if (fl || exp_stall) begin
                m_v[0] = 1'b0; m_wr[0] = 1'b0; m_ld[0] = 1'b0; m_rd[0] = 5'd0;
                m_fa = 2'b00; m_fb = 2'b00;
            end else begin
                m_v[0] = v; m_wr[0] = rw; m_ld[0] = ld; m_rd[0] = rd;
                m_fa = sel_a; m_fb = sel_b;
            end
            if (exp_stall && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            check("ex_fwd_a",    {30'd0, bus.ex_fwd_a},  {30'd0, e.fa});
            check("ex_fwd_b",    {30'd0, bus.ex_fwd_b},  {30'd0, e.fb});
            check("stall_count", {24'd0, bus.stall_count}, {24'd0, e.cnt});
        end
    endtask

    // Issue an instruction, re-presenting it while it is stalled (IF/ID frozen).
    task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic [4:0] rd,
                         input logic rw, input logic ld);
        logic st;
        for (int t = 0; t < 4; t++) begin
            cyc(v, rn, rm, urn, urm, rd, rw, ld, 1'b0, 1'b0, st);
            if (!st) return;
        end
        n_checks++; n_errors++;
        $display("FAIL stall_bound: got stalled after 4 cycles expected release");
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        sb_q.delete();
        check("rst_fwd_a",   {30'd0, bus.ex_fwd_a},    32'd0);
        check("rst_fwd_b",   {30'd0, bus.ex_fwd_b},    32'd0);
        check("rst_count",   {24'd0, bus.stall_count}, 32'd0);
        check("rst_stall",   {31'd0, bus.load_stall},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        bus.id_valid = 1'b0; bus.id_rn = 5'd0; bus.id_rm = 5'd0;
        bus.id_use_rn = 1'b0; bus.id_use_rm = 1'b0; bus.id_rd = 5'd0;
        bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.flush = 1'b0; bus.hold = 1'b0;
        model_clear();
        #2;
        do_reset();

        // EX forward: ADD X1 ; SUB X5, X1, X4
        issue(1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 0);
        issue(1, 5'd1, 5'd4, 1, 1, 5'd5, 1, 0);
        check("sub_fwd_a", {30'd0, bus.ex_fwd_a}, 32'd1);
        repeat (3) nop();

        // MEM forward on rm, then WB forward on rn
        issue(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 0);
        nop();
        issue(1, 5'd8, 5'd2, 1, 1, 5'd9, 1, 0);
        check("orr_fwd_b", {30'd0, bus.ex_fwd_b}, 32'd2);
        repeat (3) nop();
        issue(1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 0);
        nop(); nop();
        issue(1, 5'd2, 5'd8, 1, 1, 5'd10, 1, 0);
        check("and_fwd_a", {30'd0, bus.ex_fwd_a}, {30'd0, WB_CODE});
        repeat (3) nop();

        // Load-use: one stall cycle, then MEM forward
        issue(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
        issue(1, 5'd3, 5'd0, 1, 0, 5'd11, 1, 0);
        check("lu_fwd_a", {30'd0, bus.ex_fwd_a}, 32'd2);
        check("lu_count", {24'd0, bus.stall_count}, 32'd1);
        repeat (3) nop();

        // XZR: neither forwarded nor stalling
        issue(1, 5'd0, 5'd0, 0, 0, XZR, 1, 1);
        issue(1, XZR, XZR, 1, 1, 5'd12, 1, 0);
        issue(1, 5'd0, 5'd0, 0, 0, XZR, 1, 0);
        issue(1, XZR, XZR, 1, 1, 5'd12, 1, 0);
        repeat (3) nop();

        // Flush coinciding with a load-use hazard
        issue(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 1);
        cyc(1, 5'd6, 5'd0, 1, 0, 5'd13, 1, 0, 1'b1, 1'b0, st);
        repeat (3) nop();

        // Hold 3 cycles with a hazard present in ID
        issue(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1);
        repeat (3) cyc(1, 5'd0, 5'd5, 0, 1, 5'd14, 1, 0, 1'b0, 1'b1, st);
        issue(1, 5'd0, 5'd5, 0, 1, 5'd14, 1, 0);
        repeat (3) nop();

        // Chained loads X3 <- [X3] drive the counter into saturation
        for (int k = 0; k < 300; k++) issue(1, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1);
        check("sat_count", {24'd0, bus.stall_count}, {24'd0, {CNT_W{1'b1}}});

        // Reset mid-stall
        issue(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1);
        bus.id_valid = 1; bus.id_rn = 5'd7; bus.id_use_rn = 1; bus.id_use_rm = 0;
        bus.id_rd = 5'd15; bus.id_regwrite = 1; bus.id_memread = 0;
        #1;
        check("pre_rst_stall", {31'd0, bus.load_stall}, 32'd1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 5-stage ARM pipeline.
- Tracks destination registers of in-flight instructions and produces registered 2-bit operand selects for the EX stage.
- The EX-stage 4:1 operand muxes consume these selects: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result, 11 = late WB value.
- Sits in decode (ID) and drives the ID/EX pipeline boundary.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never forwarded, never causes a stall
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-low reset (state cleared on the rising clk edge while reset==0)
hold  input  1  global freeze (memory wait); all state holds
flush  input  1  squash the instruction in ID; a bubble enters EX
id_valid  input  1  ID holds a real instruction
id_rn  input  REG_W  first source register
id_rm  input  REG_W  second source register
id_use_rn  input  1  id_rn is read
id_use_rm  input  1  id_rm is read
id_rd  input  REG_W  destination register
id_regwrite  input  1  instruction writes id_rd
id_memread  input  1  instruction is a load
ex_fwd_a  output  2  registered operand A select for EX
ex_fwd_b  output  2  registered operand B select for EX
load_stall  output  1  combinational; freeze PC and IF/ID, bubble into EX
stall_count  output  CNT_W  saturating count of load_stall cycles

Behaviour:
- Internal tracking pipe with 3 slots, EX, MEM and WB. Each slot holds {v, wr, ld, rd}. A slot is "writing" when v & wr & rd!=ZERO_REG.
- Match rule for source s in {rn, rm}: match only if use_s & id_valid & s!=ZERO_REG.
- Select encoding, nearest stage wins:
  - EX slot writing with rd==s -> 01
  - else MEM slot writing with rd==s -> 10
  - else WB slot writing with rd==s -> 11
  - else 00
- load_stall = id_valid & EX.v & EX.ld & EX.rd!=ZERO_REG & (rn match | rm match) & ~flush. Combinational, no latency.
- Each rising edge with reset==1 and hold==0:
  - Shift WB<=MEM and MEM<=EX.
  - EX slot load:
    - flush or load_stall -> bubble (v=0), ex_fwd_a/b<=00.
    - otherwise EX<={id_valid, id_regwrite, id_memread, id_rd}, ex_fwd_a/b<=computed selects.
- Latency: selects computed in ID appear on ex_fwd_a/b one cycle later, aligned with the instruction in EX.
- Load-use case: stall lasts exactly 1 cycle. The next cycle the load sits in MEM, so the consumer gets 10 and load_stall deasserts.
- hold==1: all registers and stall_count hold; load_stall still computed combinationally.
- Priority: reset > hold > flush > load_stall > normal. When flush and a load-use hazard coincide, load_stall=0 (the instruction is squashed anyway).
- stall_count increments on each non-held edge where load_stall==1 and saturates at all-ones (no wrap).
- Reset (reset==0 at edge), including mid-operation:
  - all slots v=0
  - ex_fwd_a=ex_fwd_b=00, stall_count=0
  - load_stall therefore 0 in the cycle after reset.

Optional Feature:
- Macro: FWD_REGFILE_BYPASS_EN.
- Defined: the register file writes before it reads in the same cycle. WB-slot matches produce 00 instead of 11, so code 11 is never generated.
- Undefined: WB-slot matches produce 11, selecting the late WB register.

Test Plan:
- ADD X1 (regwrite, rd=1) then SUB reading rn=1 -> ex_fwd_a=01 in the SUB's EX cycle; ex_fwd_b=00.
- ADD X2, NOP, ORR reading rm=2 -> ex_fwd_b=10. ADD X2, NOP, NOP, AND reading rn=2 -> ex_fwd_a=11 (00 with FWD_REGFILE_BYPASS_EN).
- LDUR X3 then ADD reading rn=3 -> load_stall=1 for exactly one cycle and a bubble enters EX (ex_fwd=00). Next cycle ex_fwd_a=10 and stall_count=1.
- Writer with rd=31 followed by a reader of X31 -> ex_fwd=00 and no load_stall, even for a load.
- Load-use hazard with flush=1 in the same cycle -> load_stall=0 and bubble inserted. Separately, hold=1 for 3 cycles -> outputs and stall_count unchanged.
- Preload stall_count to 16'hFFFE via repeated load-use pairs, then 3 more stalls -> saturates at 16'hFFFF. Assert reset=0 for one edge mid-stall -> stall_count=0, selects=00, load_stall=0.
